mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one downstream memory port between the instruction-fetch requester (read-only) and the data requester (read/write).
- Sits between the fetch-stage instruction bus logic, the memory stage, and the single memory or cache port.
- Allows one outstanding transaction and registers the request payload at grant.
- Routes the response back to the requester that owns the transaction, and drops a fetch response when a fetch flush arrives.

Parameters:
- ADDR_W, 64, address width for both requesters and the memory port.
- DATA_W, 64, data width; the strobe width is DATA_W/8.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset: 0 = reset, sampled on posedge clock.
- i_req  in  1  fetch request; held with i_addr until i_rvalid.
- i_addr  in  ADDR_W  fetch address.
- i_flush  in  1  kill the pending or in-flight fetch (fence_i or redirect).
- i_rvalid  out  1  one-cycle fetch response pulse.
- i_rdata  out  DATA_W  fetch read data.
- i_err  out  1  fetch access error, valid with i_rvalid.
- d_req  in  1  data request; held with its payload until d_rvalid.
- d_addr  in  ADDR_W  data address.
- d_we  in  1  1 = write, 0 = read.
- d_wdata  in  DATA_W  write data.
- d_wstrb  in  DATA_W/8  byte strobes.
- d_rvalid  out  1  one-cycle data response pulse.
- d_rdata  out  DATA_W  data read data.
- d_err  out  1  data access error, valid with d_rvalid.
- mem_req  out  1  downstream request valid.
- mem_addr  out  ADDR_W  registered address.
- mem_we  out  1  registered write enable (always 0 for fetch).
- mem_wdata  out  DATA_W  registered write data.
- mem_wstrb  out  DATA_W/8  registered strobes (all 0 for fetch).
- mem_gnt  in  1  downstream accepts request this cycle.
- mem_rvalid  in  1  downstream response valid.
- mem_rdata  in  DATA_W  downstream read data.
- mem_err  in  1  downstream access error.

Behaviour:
- Reset values: state IDLE; owner = none; drop flag 0; last_owner = INST; all outputs 0.
- State machine: IDLE -> WAIT_GNT -> WAIT_RESP -> IDLE.
- IDLE:
  - When any request is present, select a winner (arbitration rule under Optional Feature).
  - Latch addr, we, wdata and wstrb into the mem_* registers; set owner.
  - mem_req=1 from the next cycle; move to WAIT_GNT.
  - Request seen in cycle N gives mem_req high in cycle N+1.
- WAIT_GNT:
  - mem_req held high with a stable payload until a cycle where mem_gnt=1.
  - That cycle, mem_req clears on the following edge and the state moves to WAIT_RESP.
  - mem_gnt together with mem_rvalid in the same cycle is legal: the response is taken and the state goes straight to IDLE.
- WAIT_RESP:
  - On mem_rvalid, register rdata and err into the owner's response outputs; pulse the owner's rvalid for exactly one cycle (the cycle after mem_rvalid).
  - Return to IDLE; the next grant may be made in that IDLE cycle.
  - Minimum request-to-rvalid latency is 3 cycles with a 0-wait memory.
- The non-owner's rvalid stays 0 throughout.
- mem_rvalid is ignored in IDLE and in WAIT_GNT when mem_gnt=0 (spurious responses are discarded).
- i_flush:
  - Owner=INST in WAIT_GNT or WAIT_RESP: set the drop flag. The transaction still completes downstream, but i_rvalid is suppressed; the flag clears on return to IDLE.
  - In IDLE: suppresses fetch selection that cycle.
  - Has no effect on data transactions.
- A fetch request must not be granted in the same cycle as i_flush.
- Reset mid-transaction: immediate return to the reset state. mem_req drops the cycle after reset is sampled low, and any later response is discarded.
- last_owner updates at every grant.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. With both requests present in IDLE, grant the requester that is not last_owner, so alternate grants under contention.
- Undefined: fixed priority, with data always winning when both are present. last_owner is still maintained but unused.
- A single requester is granted immediately in both modes.

Test Plan:
- Single fetch: i_req=1, i_addr=0x1000; memory gives mem_gnt in the first mem_req cycle and mem_rvalid next cycle with rdata=0xDEADBEEF -> mem_addr=0x1000, mem_we=0, mem_wstrb=0; i_rvalid one cycle with i_rdata=0xDEADBEEF; d_rvalid=0.
- Data write with stall: d_req=1, d_we=1, d_addr=0x2008, d_wdata=0x55, d_wstrb=0x01; mem_gnt delayed 3 cycles -> mem_req and payload stable for 4 cycles; d_rvalid pulses once after mem_rvalid.
- Contention, macro undefined: i_req and d_req held high for 4 transactions -> data wins every grant; fetch waits until d_req drops.
- Contention, MEM_ARB_ROUND_ROBIN_EN defined: both held high from reset -> grant order D, I, D, I (last_owner resets to INST).
- Flush in flight: fetch granted at 0x3000, i_flush pulsed during WAIT_RESP, mem_rvalid arrives -> no i_rvalid pulse; the next request is granted normally.
- Reset mid-op: drive reset=0 during WAIT_GNT -> mem_req=0 next cycle; a mem_rvalid arriving after reset release produces no i_rvalid or d_rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between the fetch (read-only) and data (read/write) requesters.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of data-first priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic                  i_flush,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic                  d_we,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_err
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_GNT  = 2'd1;
    localparam logic [1:0] ST_WAIT_RESP = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_INST = 2'd1;
    localparam logic [1:0] OWN_DATA = 2'd2;

    localparam logic LAST_INST = 1'b0;
    localparam logic LAST_DATA = 1'b1;

    logic [1:0]        r_state;
    logic [1:0]        r_owner;
    logic              r_drop;
    logic              r_last_owner;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [STRB_W-1:0] r_mem_wstrb;
    logic              r_i_rvalid;
    logic [DATA_W-1:0] r_i_rdata;
    logic              r_i_err;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_d_err;

    logic              w_i_cand;
    logic              w_d_cand;
    logic              w_pick_data;
    logic              w_grant;
    logic              w_flush_own;
    logic              w_resp_take;
    logic              w_resp_inst;
    logic              w_resp_data;

    logic [1:0]        w_state_nxt;
    logic [1:0]        w_owner_nxt;
    logic              w_drop_nxt;
    logic              w_last_nxt;
    logic              w_mem_req_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic              w_mem_we_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic [STRB_W-1:0] w_mem_wstrb_nxt;

    // Arbitration and response qualification; a flush blocks fetch selection in the same cycle
    always_comb begin
        w_i_cand = i_req & ~i_flush;
        w_d_cand = d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (w_i_cand && w_d_cand) begin
            w_pick_data = (r_last_owner == LAST_INST);
        end else begin
            w_pick_data = w_d_cand;
        end
`else
        w_pick_data = w_d_cand;
`endif
        w_grant     = (r_state == ST_IDLE) && (w_i_cand || w_d_cand);
        w_flush_own = i_flush && (r_owner == OWN_INST);
        w_resp_take = ((r_state == ST_WAIT_GNT) && mem_gnt && mem_rvalid) ||
                      ((r_state == ST_WAIT_RESP) && mem_rvalid);
        // A flush landing in the completion cycle also kills the fetch response
        w_resp_inst = w_resp_take && (r_owner == OWN_INST) && !r_drop && !i_flush;
        w_resp_data = w_resp_take && (r_owner == OWN_DATA);
    end

    // Transaction state machine and downstream payload next-state
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_drop_nxt      = r_drop;
        w_last_nxt      = r_last_owner;
        w_mem_req_nxt   = r_mem_req;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_we_nxt    = r_mem_we;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_wstrb_nxt = r_mem_wstrb;
        case (r_state)
            ST_IDLE: begin
                w_drop_nxt = 1'b0;
                if (w_grant) begin
                    w_state_nxt   = ST_WAIT_GNT;
                    w_mem_req_nxt = 1'b1;
                    if (w_pick_data) begin
                        w_owner_nxt     = OWN_DATA;
                        w_last_nxt      = LAST_DATA;
                        w_mem_addr_nxt  = d_addr;
                        w_mem_we_nxt    = d_we;
                        w_mem_wdata_nxt = d_wdata;
                        w_mem_wstrb_nxt = d_wstrb;
                    end else begin
                        w_owner_nxt     = OWN_INST;
                        w_last_nxt      = LAST_INST;
                        w_mem_addr_nxt  = i_addr;
                        w_mem_we_nxt    = 1'b0;
                        w_mem_wdata_nxt = {DATA_W{1'b0}};
                        w_mem_wstrb_nxt = {STRB_W{1'b0}};
                    end
                end else begin
                    w_owner_nxt   = OWN_NONE;
                    w_mem_req_nxt = 1'b0;
                end
            end
            ST_WAIT_GNT: begin
                if (mem_gnt) begin
                    w_mem_req_nxt = 1'b0;
                    if (mem_rvalid) begin
                        w_state_nxt = ST_IDLE;
                        w_owner_nxt = OWN_NONE;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_WAIT_RESP;
                        w_drop_nxt  = r_drop | w_flush_own;
                    end
                end else begin
                    w_drop_nxt = r_drop | w_flush_own;
                end
            end
            ST_WAIT_RESP: begin
                if (mem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                    w_owner_nxt = OWN_NONE;
                    w_drop_nxt  = 1'b0;
                end else begin
                    w_drop_nxt = r_drop | w_flush_own;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_owner_nxt   = OWN_NONE;
                w_drop_nxt    = 1'b0;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // State, payload and response registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_NONE;
            r_drop       <= 1'b0;
            r_last_owner <= LAST_INST;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= {ADDR_W{1'b0}};
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= {DATA_W{1'b0}};
            r_mem_wstrb  <= {STRB_W{1'b0}};
            r_i_rvalid   <= 1'b0;
            r_i_rdata    <= {DATA_W{1'b0}};
            r_i_err      <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_d_rdata    <= {DATA_W{1'b0}};
            r_d_err      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_drop       <= w_drop_nxt;
            r_last_owner <= w_last_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_wstrb  <= w_mem_wstrb_nxt;
            r_i_rvalid   <= w_resp_inst;
            r_d_rvalid   <= w_resp_data;
            if (w_resp_inst) begin
                r_i_rdata <= mem_rdata;
                r_i_err   <= mem_err;
            end
            if (w_resp_data) begin
                r_d_rdata <= mem_rdata;
                r_d_err   <= mem_err;
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign i_rvalid  = r_i_rvalid;
    assign i_rdata   = r_i_rdata;
    assign i_err     = r_i_err;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;

endmodule
